pci_arbiter: RTL

//  Central PCI bus arbiter; it is the other end of each device's REQ/GNT pair.
//  It samples the active-low REQ lines from all bus devices and selects one owner by round-robin.
//  It drives that owner's active-low GNT, then tracks FRAME/IRDY on the shared bus until the transaction ends.
//  It sits at top level beside the Device instances (A/B/C) and owns no AD/C_BE traffic.

---
 rtl/pci_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pci_arbiter.sv
// Central PCI bus arbiter: round-robin REQ/GNT handshake with FRAME/IRDY tracking.
// Owns no AD/C_BE traffic; only grant sequencing, turnaround and grant timeout.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | bus free, arbitrate among active REQ lines
// GRANT   | GNT driven to owner, waiting for FRAME (timeout counter runs)
// BUSY    | transaction on bus, wait for FRAME and IRDY both high
// TURN    | one-cycle turnaround with all GNT high
module pci_arbiter #(
  parameter int N_DEV       = 3,
  parameter int GNT_TIMEOUT = 16,
  parameter int OW          = 2
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [N_DEV-1:0] REQ,
  output logic [N_DEV-1:0] GNT,
  input  logic             FRAME,
  input  logic             IRDY,
  output logic [OW-1:0]    OWNER,
  output logic             BUS_BUSY,
  output logic             TIMEOUT
);

  localparam int               CNT_W    = $clog2(GNT_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GNT_TIMEOUT - 1);
  localparam logic [OW-1:0]    LAST_RST = OW'(N_DEV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_BUSY,
    ST_TURN
  } state_t;

  state_t             state_q, state_d;
  logic [N_DEV-1:0]   gnt_q, gnt_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bus_busy_q, bus_busy_d;
  logic               timeout_q, timeout_d;

  logic [N_DEV-1:0]   req_act;
  logic               frame_act;
  logic               irdy_act;
  logic               win_found;
  logic [OW-1:0]      win_idx;
  logic [OW-1:0]      scan_idx;

  // A floating (z/x) bus line must never read as asserted.
  always_comb begin
    for (int i = 0; i < N_DEV; i++) begin
      req_act[i] = (REQ[i] === 1'b0);
    end
    frame_act = (FRAME === 1'b0);
    irdy_act  = (IRDY === 1'b0);
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 1; i <= N_DEV; i++) begin
      scan_idx = OW'((int'(last_q) + i) % N_DEV);
      if (!win_found && req_act[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        gnt_d = '1;
        // A foreign master already on the bus takes precedence over arbitration.
        if (frame_act) begin
          state_d = ST_BUSY;
        end else if (win_found) begin
          gnt_d[win_idx] = 1'b0;
          owner_d        = win_idx;
          last_d         = win_idx;
          cnt_d          = '0;
          state_d        = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (frame_act) begin
          gnt_d   = '1;
          state_d = ST_BUSY;
        end else if (!req_act[owner_q]) begin
          gnt_d   = '1;
          state_d = ST_TURN;
        end else if (cnt_q == CNT_LAST) begin
          gnt_d     = '1;
          timeout_d = 1'b0;
          state_d   = ST_TURN;
        end
      end
      ST_BUSY: begin
        gnt_d = '1;
        if (!frame_act && !irdy_act) begin
          state_d = ST_TURN;
        end
      end
      ST_TURN: begin
        gnt_d   = '1;
        state_d = frame_act ? ST_BUSY : ST_IDLE;
      end
      default: begin
        gnt_d   = '1;
        state_d = ST_IDLE;
      end
    endcase

    bus_busy_d = !((state_d == ST_GRANT) || (state_d == ST_BUSY));
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '1;
      owner_q    <= '0;
      last_q     <= LAST_RST;
      cnt_q      <= '0;
      bus_busy_q <= 1'b1;
      timeout_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      bus_busy_q <= bus_busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign GNT      = gnt_q;
  assign OWNER    = owner_q;
  assign BUS_BUSY = bus_busy_q;
  assign TIMEOUT  = timeout_q;

endmodule
